// File: rtl/bp_fe_ltb_update_queue_pkg.sv
// ---------------------------------------------------------------------------
// bp_fe_ltb_update_queue_pkg
//   Shared types and configuration helpers for the LTB update queue.
//   - bp_params_e              : processor configuration selector
//   - bp_vaddr_width()         : virtual address width for a configuration
//   - bp_ltb_cnt_width()       : LTB counter width for a configuration
//   - `DECLARE_BP_FE_LTB_UPDATE_S(vaddr_width_mp, ltb_cnt_width_mp)
//                              : declares the packed update record
//                                bp_fe_ltb_update_s in the calling scope
//   No ports (package).
// ---------------------------------------------------------------------------

// The record width depends on the instance's parameters, so it is declared
// through a macro inside each user rather than as a fixed package type.
`define DECLARE_BP_FE_LTB_UPDATE_S(vaddr_width_mp, ltb_cnt_width_mp) \
    typedef struct packed {                                           \
        logic                        mispredict;                      \
        logic                        taken;                           \
        logic                        conf;                            \
        logic [vaddr_width_mp-1:0]   src_addr;                        \
        logic [ltb_cnt_width_mp-1:0] non_spec_cnt;                    \
        logic [ltb_cnt_width_mp-1:0] trip_cnt;                        \
    } bp_fe_ltb_update_s

package bp_fe_ltb_update_queue_pkg;

    typedef enum logic [0:0] {
        e_bp_default_cfg = 1'b0
    } bp_params_e;

    function automatic int bp_vaddr_width(input bp_params_e cfg);
        case (cfg)
            e_bp_default_cfg: return 39;
            default:          return 39;
        endcase
    endfunction

    function automatic int bp_ltb_cnt_width(input bp_params_e cfg);
        case (cfg)
            e_bp_default_cfg: return 8;
            default:          return 8;
        endcase
    endfunction

endpackage

// File: rtl/bp_fe_ltb_update_queue_mem.sv
// ---------------------------------------------------------------------------
// bp_fe_ltb_update_queue_mem
//   1-read/1-write register-file storage for the update queue.
//   Synchronous write, asynchronous (combinational) read of one entry.
//   Ports:
//     clk_i     in   1         clock
//     w_v_i     in   1         write enable
//     w_addr_i  in   addr_w    write index
//     w_data_i  in   width_p   write data
//     r_addr_i  in   addr_w    read index
//     r_data_o  out  width_p   read data (async)
// ---------------------------------------------------------------------------
module bp_fe_ltb_update_queue_mem #(
    parameter int width_p = 8,
    parameter int els_p   = 4,
    localparam int addr_w = $clog2(els_p)
) (
    input  logic               clk_i,
    input  logic               w_v_i,
    input  logic [addr_w-1:0]  w_addr_i,
    input  logic [width_p-1:0] w_data_i,
    input  logic [addr_w-1:0]  r_addr_i,
    output logic [width_p-1:0] r_data_o
);

    logic [width_p-1:0] mem_q [els_p];

    // NOTE: storage is deliberately not reset; validity is tracked by the
    // queue's count, so clearing the array would only cost reset fan-out.
    always_ff @(posedge clk_i) begin
        if (w_v_i) begin
            mem_q[w_addr_i] <= w_data_i;
        end
    end

    assign r_data_o = mem_q[r_addr_i];

endmodule

// File: rtl/bp_fe_ltb_update_queue.sv
// ---------------------------------------------------------------------------
// bp_fe_ltb_update_queue
//   Elastic FIFO between branch resolution and the LTB write port. Updates
//   are accepted one per cycle, held until the LTB finishes init, then
//   replayed strictly in order; the LTB consumes the head with w_yumi_i.
//   Optional feature macro: BP_FE_LTB_UPDQ_BYPASS_EN -- when the queue is
//   empty in e_run, the incoming update is presented directly on w_*.
//   Ports:
//     clk_i, reset_i (sync, active-high), ltb_init_done_i
//     upd_v_i / upd_ready_o + upd_* fields      : enqueue side (valid/ready)
//     w_v_o / w_yumi_i + w_* fields             : dequeue side (valid/yumi)
//     count_o                                   : occupancy 0..els_p
// ---------------------------------------------------------------------------
module bp_fe_ltb_update_queue
    import bp_fe_ltb_update_queue_pkg::*;
#(
    parameter bp_params_e bp_params_p = e_bp_default_cfg,
    parameter int els_p = 4,
    localparam int vaddr_width_p   = bp_vaddr_width(bp_params_p),
    localparam int ltb_cnt_width_p = bp_ltb_cnt_width(bp_params_p),
    localparam int cnt_w           = $clog2(els_p + 1)
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       ltb_init_done_i,

    input  logic                       upd_v_i,
    output logic                       upd_ready_o,
    input  logic                       upd_mispredict_i,
    input  logic                       upd_taken_i,
    input  logic                       upd_conf_i,
    input  logic [vaddr_width_p-1:0]   upd_src_addr_i,
    input  logic [ltb_cnt_width_p-1:0] upd_non_spec_cnt_i,
    input  logic [ltb_cnt_width_p-1:0] upd_trip_cnt_i,

    output logic                       w_v_o,
    output logic                       w_mispredict_o,
    output logic                       w_taken_o,
    output logic                       w_conf_o,
    output logic [vaddr_width_p-1:0]   w_src_addr_o,
    output logic [ltb_cnt_width_p-1:0] w_non_spec_cnt_o,
    output logic [ltb_cnt_width_p-1:0] w_trip_cnt_o,
    input  logic                       w_yumi_i,

    output logic [cnt_w-1:0]           count_o
);

    localparam int ptr_w = $clog2(els_p);

    `DECLARE_BP_FE_LTB_UPDATE_S(vaddr_width_p, ltb_cnt_width_p);

    typedef enum logic [1:0] {
        e_reset = 2'd0,
        e_wait  = 2'd1,
        e_run   = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [ptr_w-1:0]   wr_ptr_q, wr_ptr_d;
    logic [ptr_w-1:0]   rd_ptr_q, rd_ptr_d;
    logic [cnt_w-1:0]   count_q, count_d;

    bp_fe_ltb_update_s  upd_li, head_lo, w_lo;
    logic               full, empty, run;
    logic               enq_fire, bypass_v;
    logic               mem_w_v, mem_deq;

    // ---------------- FSM next state ----------------
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            e_reset: state_d = e_wait;
            e_wait:  if (ltb_init_done_i) state_d = e_run;
            e_run:   state_d = e_run;
            default: state_d = e_reset;
        endcase
    end

    // ---------------- handshake ----------------
    assign full  = (count_q == cnt_w'(els_p));
    assign empty = (count_q == '0);
    assign run   = (state_q == e_run);

    // Ready depends only on registered state, never on w_yumi_i.
    assign upd_ready_o = ~full & (state_q != e_reset);
    assign enq_fire    = upd_v_i & upd_ready_o;

`ifdef BP_FE_LTB_UPDQ_BYPASS_EN
    assign bypass_v = empty & run;
`else
    assign bypass_v = 1'b0;
`endif

    assign upd_li = '{
        mispredict:   upd_mispredict_i,
        taken:        upd_taken_i,
        conf:         upd_conf_i,
        src_addr:     upd_src_addr_i,
        non_spec_cnt: upd_non_spec_cnt_i,
        trip_cnt:     upd_trip_cnt_i
    };

    always_comb begin
        w_v_o   = ~empty & run;
        w_lo    = head_lo;
        mem_w_v = enq_fire;
        mem_deq = w_yumi_i;
        if (bypass_v) begin
            // Empty queue: present the incoming update directly. If the LTB
            // takes it this cycle it never touches storage.
            w_v_o   = upd_v_i;
            w_lo    = upd_li;
            mem_w_v = enq_fire & ~w_yumi_i;
            mem_deq = 1'b0;
        end
    end

    assign w_mispredict_o   = w_lo.mispredict;
    assign w_taken_o        = w_lo.taken;
    assign w_conf_o         = w_lo.conf;
    assign w_src_addr_o     = w_lo.src_addr;
    assign w_non_spec_cnt_o = w_lo.non_spec_cnt;
    assign w_trip_cnt_o     = w_lo.trip_cnt;
    assign count_o          = count_q;

    // ---------------- pointers and occupancy ----------------
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (mem_w_v) wr_ptr_d = wr_ptr_q + ptr_w'(1);
        if (mem_deq) rd_ptr_d = rd_ptr_q + ptr_w'(1);
        case ({mem_w_v, mem_deq})
            2'b10:   count_d = count_q + cnt_w'(1);
            2'b01:   count_d = count_q - cnt_w'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: non-blocking assignments so every flop samples pre-edge values
    // regardless of block evaluation order.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= e_reset;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    bp_fe_ltb_update_queue_mem #(
        .width_p ($bits(bp_fe_ltb_update_s)),
        .els_p   (els_p)
    ) u_mem (
        .clk_i    (clk_i),
        .w_v_i    (mem_w_v),
        .w_addr_i (wr_ptr_q),
        .w_data_i (upd_li),
        .r_addr_i (rd_ptr_q),
        .r_data_o (head_lo)
    );

    // Consuming an entry that is not being offered is a protocol error.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            assert (!(w_yumi_i && !w_v_o));
        end
    end

endmodule

// File: tb/tb_bp_fe_ltb_update_queue.sv
module tb_bp_fe_ltb_update_queue;
    import bp_fe_ltb_update_queue_pkg::*;

    localparam int vw    = bp_vaddr_width(e_bp_default_cfg);
    localparam int cw    = bp_ltb_cnt_width(e_bp_default_cfg);
    localparam int els   = 4;
    localparam int cnt_w = $clog2(els + 1);

    typedef struct packed {
        logic          mispredict;
        logic          taken;
        logic          conf;
        logic [vw-1:0] src_addr;
        logic [cw-1:0] non_spec_cnt;
        logic [cw-1:0] trip_cnt;
    } upd_t;

    logic             clk = 1'b0;
    logic             reset_i = 1'b1;
    logic             ltb_init_done_i = 1'b0;
    logic             upd_v_i = 1'b0;
    logic             upd_ready_o;
    logic             upd_mispredict_i = 1'b0;
    logic             upd_taken_i = 1'b0;
    logic             upd_conf_i = 1'b0;
    logic [vw-1:0]    upd_src_addr_i = '0;
    logic [cw-1:0]    upd_non_spec_cnt_i = '0;
    logic [cw-1:0]    upd_trip_cnt_i = '0;
    logic             w_v_o;
    logic             w_mispredict_o, w_taken_o, w_conf_o;
    logic [vw-1:0]    w_src_addr_o;
    logic [cw-1:0]    w_non_spec_cnt_o, w_trip_cnt_o;
    logic             w_yumi_i = 1'b0;
    logic [cnt_w-1:0] count_o;

    int   n_vec = 0;
    int   n_err = 0;
    upd_t sb[$];
    logic last_ready, last_wv;

`ifdef BP_FE_LTB_UPDQ_BYPASS_EN
    localparam bit bypass_on = 1'b1;
`else
    localparam bit bypass_on = 1'b0;
`endif

    always #5 clk = ~clk;

    bp_fe_ltb_update_queue #(.bp_params_p(e_bp_default_cfg), .els_p(els)) dut (
        .clk_i              (clk),
        .reset_i            (reset_i),
        .ltb_init_done_i    (ltb_init_done_i),
        .upd_v_i            (upd_v_i),
        .upd_ready_o        (upd_ready_o),
        .upd_mispredict_i   (upd_mispredict_i),
        .upd_taken_i        (upd_taken_i),
        .upd_conf_i         (upd_conf_i),
        .upd_src_addr_i     (upd_src_addr_i),
        .upd_non_spec_cnt_i (upd_non_spec_cnt_i),
        .upd_trip_cnt_i     (upd_trip_cnt_i),
        .w_v_o              (w_v_o),
        .w_mispredict_o     (w_mispredict_o),
        .w_taken_o          (w_taken_o),
        .w_conf_o           (w_conf_o),
        .w_src_addr_o       (w_src_addr_o),
        .w_non_spec_cnt_o   (w_non_spec_cnt_o),
        .w_trip_cnt_o       (w_trip_cnt_o),
        .w_yumi_i           (w_yumi_i),
        .count_o            (count_o)
    );

    // Distinct, PC-derived field patterns so reordering or field swaps show up.
    function automatic upd_t mk(input int pc);
        logic [31:0] p;
        upd_t u;
        p = pc;
        u.mispredict   = p[2];
        u.taken        = p[3];
        u.conf         = p[4];
        u.src_addr     = vw'(p);
        u.non_spec_cnt = p[7:0] ^ 8'h5a;
        u.trip_cnt     = p[11:4];
        return u;
    endfunction

    // One clock: drive at negedge, settle, record handshakes, cross posedge.
    task automatic cycle(input logic v, input upd_t u, input logic yumi_req);
        upd_t got, exp;
        w_yumi_i           = 1'b0;
        upd_v_i            = v;
        upd_mispredict_i   = u.mispredict;
        upd_taken_i        = u.taken;
        upd_conf_i         = u.conf;
        upd_src_addr_i     = u.src_addr;
        upd_non_spec_cnt_i = u.non_spec_cnt;
        upd_trip_cnt_i     = u.trip_cnt;
        #1;
        w_yumi_i = yumi_req & w_v_o;
        #1;
        last_ready = upd_ready_o;
        last_wv    = w_v_o;
        if (upd_v_i && upd_ready_o && !reset_i) sb.push_back(u);
        if (w_v_o && w_yumi_i) begin
            n_vec++;
            got = '{w_mispredict_o, w_taken_o, w_conf_o, w_src_addr_o,
                    w_non_spec_cnt_o, w_trip_cnt_o};
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL w_unexpected: got %h, scoreboard empty", got);
            end else begin
                exp = sb.pop_front();
                if (got !== exp) begin
                    n_err++;
                    $display("FAIL w_data: got %h want %h", got, exp);
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
        w_yumi_i = 1'b0;
        upd_v_i  = 1'b0;
    endtask

    task automatic drain(input string name);
        int guard = 0;
        while (sb.size() > 0 && guard < 64) begin
            cycle(1'b0, mk(0), 1'b1);
            guard++;
        end
        n_vec++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL %s_drain_timeout: %0d left, want 0", name, sb.size());
        end
        n_vec++;
        if (count_o !== '0) begin
            n_err++;
            $display("FAIL %s_drain_count: got %0d want 0", name, count_o);
        end
    endtask

    task automatic test_reset();
        reset_i = 1'b1;
        cycle(1'b0, mk(0), 1'b0);
        cycle(1'b0, mk(0), 1'b0);
        n_vec++;
        if ({upd_ready_o, w_v_o, count_o} !== {1'b0, 1'b0, cnt_w'(0)}) begin
            n_err++;
            $display("FAIL reset_outputs: got ready=%b wv=%b cnt=%0d want 0/0/0",
                     upd_ready_o, w_v_o, count_o);
        end
        reset_i = 1'b0;
        cycle(1'b0, mk(0), 1'b0);
        n_vec++;
        if ({upd_ready_o, w_v_o, count_o} !== {1'b1, 1'b0, cnt_w'(0)}) begin
            n_err++;
            $display("FAIL wait_outputs: got ready=%b wv=%b cnt=%0d want 1/0/0",
                     upd_ready_o, w_v_o, count_o);
        end
    endtask

    task automatic test_init_hold();
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, mk(32'h10 * (i + 1)), 1'b1);
            n_vec++;
            if (last_wv !== 1'b0) begin
                n_err++;
                $display("FAIL init_hold_wv%0d: got %b want 0", i, last_wv);
            end
        end
        n_vec++;
        if (count_o !== cnt_w'(3)) begin
            n_err++;
            $display("FAIL init_hold_count: got %0d want 3", count_o);
        end
        ltb_init_done_i = 1'b1;
        cycle(1'b0, mk(0), 1'b0);
        n_vec++;
        if (w_v_o !== 1'b1) begin
            n_err++;
            $display("FAIL init_release_wv: got %b want 1", w_v_o);
        end
        drain("init");
    endtask

    task automatic test_fill();
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, mk(32'h200 + 4 * i), 1'b0);
            n_vec++;
            if (last_ready !== (i < 4)) begin
                n_err++;
                $display("FAIL fill_ready%0d: got %b want %b", i, last_ready, (i < 4));
            end
        end
        n_vec++;
        if ({count_o, upd_ready_o} !== {cnt_w'(4), 1'b0}) begin
            n_err++;
            $display("FAIL fill_full: got cnt=%0d ready=%b want 4/0", count_o, upd_ready_o);
        end
    endtask

    task automatic test_full_drain();
        cycle(1'b1, mk(32'h300), 1'b1);
        n_vec++;
        if (last_ready !== 1'b0) begin
            n_err++;
            $display("FAIL full_yumi_ready: got %b want 0", last_ready);
        end
        n_vec++;
        if ({count_o, upd_ready_o} !== {cnt_w'(3), 1'b1}) begin
            n_err++;
            $display("FAIL full_after: got cnt=%0d ready=%b want 3/1", count_o, upd_ready_o);
        end
        drain("full");
    endtask

    task automatic test_stream();
        logic [cnt_w-1:0] exp_cnt;
        exp_cnt = bypass_on ? cnt_w'(0) : cnt_w'(1);
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, mk(32'h100 + 4 * i), 1'b1);
            n_vec++;
            if (count_o !== exp_cnt) begin
                n_err++;
                $display("FAIL stream_count%0d: got %0d want %0d", i, count_o, exp_cnt);
            end
        end
        drain("stream");
    endtask

    task automatic test_reset_mid();
        cycle(1'b1, mk(32'h400), 1'b0);
        cycle(1'b1, mk(32'h404), 1'b0);
        n_vec++;
        if (count_o !== cnt_w'(2)) begin
            n_err++;
            $display("FAIL mid_pre_count: got %0d want 2", count_o);
        end
        reset_i = 1'b1;
        cycle(1'b0, mk(0), 1'b0);
        n_vec++;
        if ({upd_ready_o, w_v_o, count_o} !== {1'b0, 1'b0, cnt_w'(0)}) begin
            n_err++;
            $display("FAIL mid_reset: got ready=%b wv=%b cnt=%0d want 0/0/0",
                     upd_ready_o, w_v_o, count_o);
        end
        sb.delete();
        reset_i = 1'b0;
        cycle(1'b0, mk(0), 1'b0);
        cycle(1'b0, mk(0), 1'b0);
        n_vec++;
        if ({upd_ready_o, w_v_o, count_o} !== {1'b1, 1'b0, cnt_w'(0)}) begin
            n_err++;
            $display("FAIL mid_recover: got ready=%b wv=%b cnt=%0d want 1/0/0",
                     upd_ready_o, w_v_o, count_o);
        end
    endtask

    task automatic test_bypass();
        cycle(1'b1, mk(32'h80), 1'b1);
        n_vec++;
        if (last_wv !== bypass_on) begin
            n_err++;
            $display("FAIL bypass_wv: got %b want %b", last_wv, bypass_on);
        end
        n_vec++;
        if (count_o !== (bypass_on ? cnt_w'(0) : cnt_w'(1))) begin
            n_err++;
            $display("FAIL bypass_count: got %0d want %0d", count_o, !bypass_on);
        end
        drain("bypass");
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_init_hold();
        test_fill();
        test_full_drain();
        test_stream();
        test_reset_mid();
        test_bypass();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
